// File: rtl/fc_tx_credit_scheduler_pkg.sv
// fc_tx_credit_scheduler_pkg
//   Shared flow-control definitions for the TX credit scheduler:
//   FSM state type, traffic-class indices, and credit-check width and
//   half-range constants.
package fc_tx_credit_scheduler_pkg;

    localparam int FC_W    = 10;
    localparam int NUM_CLS = 3;

    // Class indices used for every per-class array in the scheduler
    localparam logic [1:0] CLS_P   = 2'd0;
    localparam logic [1:0] CLS_NP  = 2'd1;
    localparam logic [1:0] CLS_CPL = 2'd2;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } fc_state_e;

    // A credit check passes while the remaining margin is within half the
    // counter range; anything above that is a negative margin after wrap.
    function automatic int unsigned fc_half_range(input int w);
        return 32'd1 << (w - 1);
    endfunction

    localparam int unsigned FC_HALF = fc_half_range(FC_W);

    // Round-robin successor: P -> NP -> CPL -> P
    function automatic logic [1:0] cls_next(input logic [1:0] c);
        return (c == CLS_CPL) ? CLS_P : c + 2'd1;
    endfunction

endpackage

// File: rtl/fc_tx_credit_scheduler_if.sv
// fc_tx_credit_scheduler_if
//   Request/grant bundle between the TLP requesters and the scheduler.
//   master : requester side  (drives *_req / *_dc, receives *_gnt)
//   slave  : scheduler side  (receives *_req / *_dc, drives *_gnt)
//   *_req : TLP pending per class (Posted, Non-Posted, Completion)
//   *_dc  : data credits the pending TLP needs (0 = no payload)
//   *_gnt : one-cycle grant pulse, one-hot across classes
interface fc_tx_credit_scheduler_if
    import fc_tx_credit_scheduler_pkg::*;
#(
    parameter int W = FC_W
);
    logic         p_req, np_req, cpl_req;
    logic [W-1:0] p_dc, np_dc, cpl_dc;
    logic         p_gnt, np_gnt, cpl_gnt;

    modport master (
        output p_req, np_req, cpl_req, p_dc, np_dc, cpl_dc,
        input  p_gnt, np_gnt, cpl_gnt
    );

    modport slave (
        input  p_req, np_req, cpl_req, p_dc, np_dc, cpl_dc,
        output p_gnt, np_gnt, cpl_gnt
    );
endinterface

// File: rtl/fc_tx_credit_scheduler_credit_check.sv
// fc_credit_check
//   Single flow-control credit test.
//   limit    : advertised credit limit (W bits, modulo counter)
//   consumed : credits already consumed (W bits, modulo counter)
//   need     : credits the pending TLP would consume
//   pass     : 1 when (limit - (consumed + need)) mod 2^W <= 2^(W-1)
module fc_credit_check
    import fc_tx_credit_scheduler_pkg::*;
#(
    parameter int W = FC_W
) (
    input  logic [W-1:0] limit,
    input  logic [W-1:0] consumed,
    input  logic [W-1:0] need,
    output logic         pass
);
    localparam logic [W-1:0] HALF = W'(fc_half_range(W));

    logic [W-1:0] margin;

    // All terms are W bits, so the subtraction wraps modulo 2^W
    assign margin = limit - (consumed + need);
    assign pass   = (margin <= HALF);
endmodule

// File: rtl/fc_tx_credit_scheduler.sv
// fc_tx_credit_scheduler
//   Round-robin TX scheduler for P / NP / CPL TLPs gated by flow-control
//   credits. Tracks six consumed-credit counters and grants at most one TLP
//   every two cycles (ARB then GRANT).
//   clk, rst_n        : clock, async active-low reset (deassertion synced)
//   fc_init_done      : credit limits valid; low forces INIT and clears state
//   *_credit_limit    : header/data limits for P (ph/pd), NP (nph/npd),
//                       CPL (ch/cd)
//   tx_full           : TX buffer cannot accept a write
//   req_if (slave)    : per-class req/dc in, one-hot gnt pulses out
//   tx_wr_en          : TX buffer write strobe (OR of grants)
//   cred_blocked      : [2]=P [1]=NP [0]=CPL, req pending but credits short
module fc_tx_credit_scheduler
    import fc_tx_credit_scheduler_pkg::*;
#(
    parameter int INFO_SIGNALS = FC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fc_init_done,
    input  logic [INFO_SIGNALS-1:0] ph_credit_limit,
    input  logic [INFO_SIGNALS-1:0] pd_credit_limit,
    input  logic [INFO_SIGNALS-1:0] nph_credit_limit,
    input  logic [INFO_SIGNALS-1:0] npd_credit_limit,
    input  logic [INFO_SIGNALS-1:0] ch_credit_limit,
    input  logic [INFO_SIGNALS-1:0] cd_credit_limit,
    input  logic                    tx_full,
    fc_tx_credit_scheduler_if.slave req_if,
    output logic                    tx_wr_en,
    output logic [2:0]              cred_blocked
);
    localparam int W = INFO_SIGNALS;
    localparam logic [W-1:0] ONE = W'(1);

    // Reset: asserts asynchronously, releases on a clock edge
    logic [1:0] rst_sync;
    logic       rst_n_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_s = rst_sync[1];

    // Per-class views, index = class (P=0, NP=1, CPL=2)
    logic [NUM_CLS-1:0][W-1:0] hdr_lim, dat_lim, need_dc;
    logic [NUM_CLS-1:0][W-1:0] hdr_cons, dat_cons;
    logic [NUM_CLS-1:0]        req, hdr_ok, dat_ok, elig, blk;

    assign hdr_lim = {ch_credit_limit, nph_credit_limit, ph_credit_limit};
    assign dat_lim = {cd_credit_limit, npd_credit_limit, pd_credit_limit};
    assign need_dc = {req_if.cpl_dc, req_if.np_dc, req_if.p_dc};
    assign req     = {req_if.cpl_req, req_if.np_req, req_if.p_req};

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_cls
        fc_credit_check #(.W(W)) u_hdr_chk (
            .limit    (hdr_lim[c]),
            .consumed (hdr_cons[c]),
            .need     (ONE),
            .pass     (hdr_ok[c])
        );
        fc_credit_check #(.W(W)) u_dat_chk (
            .limit    (dat_lim[c]),
            .consumed (dat_cons[c]),
            .need     (need_dc[c]),
            .pass     (dat_ok[c])
        );
    end

    assign blk  = req & ~(hdr_ok & dat_ok);
    assign elig = req & hdr_ok & dat_ok & {NUM_CLS{~tx_full}};

    // Round-robin pick: rr holds the highest-priority class
    fc_state_e  state;
    logic [1:0] rr, rr_1, rr_2, pick, sel;
    logic [W-1:0] sel_dc;

    assign rr_1 = cls_next(rr);
    assign rr_2 = cls_next(rr_1);

    always_comb begin
        if (elig[rr])        pick = rr;
        else if (elig[rr_1]) pick = rr_1;
        else                 pick = rr_2;
    end

    // The grant pulse must drop in the same cycle tx_full rises or
    // fc_init_done falls, so those two gate the registered choice directly.
    logic gnt_fire;
    assign gnt_fire       = (state == GRANT) && !tx_full && fc_init_done;
    assign req_if.p_gnt   = gnt_fire && (sel == CLS_P);
    assign req_if.np_gnt  = gnt_fire && (sel == CLS_NP);
    assign req_if.cpl_gnt = gnt_fire && (sel == CLS_CPL);
    assign tx_wr_en       = gnt_fire;

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state        <= INIT;
            sel          <= CLS_P;
            sel_dc       <= '0;
            rr           <= CLS_P;
            hdr_cons     <= '0;
            dat_cons     <= '0;
            cred_blocked <= '0;
        end else if (!fc_init_done) begin
            state        <= INIT;
            rr           <= CLS_P;
            hdr_cons     <= '0;
            dat_cons     <= '0;
            cred_blocked <= '0;
        end else begin
            cred_blocked <= (state == INIT) ? 3'b000
                                            : {blk[CLS_P], blk[CLS_NP], blk[CLS_CPL]};
            unique case (state)
                INIT: state <= ARB;
                ARB: begin
                    if (|elig) begin
                        sel    <= pick;
                        sel_dc <= need_dc[pick];
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!tx_full) begin
                        hdr_cons[sel] <= hdr_cons[sel] + ONE;
                        dat_cons[sel] <= dat_cons[sel] + sel_dc;
                        rr            <= cls_next(sel);
                        state         <= ARB;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule
